// File: rtl/pci_target_mem.sv
// pci_target_mem: parametrised PCI memory-space target with linear bursts, disconnect and target-abort.
// Defining PCI_TGT_PERR_EN builds write-data parity checking that drives PERR.
module pci_target_mem #(
    parameter logic [31:0] BASE_AD      = 32'hFFFF0000,
    parameter int          DEPTH_LOG2   = 2,
    parameter int          DEVSEL_DELAY = 0,
    parameter int          WAIT_STATES  = 0
) (
    input  logic        CLK,
    input  logic        REST,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic [3:0]  CBE,
    inout  wire  [31:0] AD,
    inout  wire         PAR,
    output logic        TRDY,
    output logic        DEVSEL,
    output logic        STOP,
    output logic        PERR
);
    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [31:0] WIN_MASK = ~((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1);
    localparam logic [2:0]  WS       = 3'(WAIT_STATES);
    localparam logic [1:0]  DD       = 2'(DEVSEL_DELAY);

    typedef enum logic [2:0] {IDLE, BUS_BUSY, DECODE, WAIT, DATA, STOPPING, TURN_AR} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   index_q, index_d;
    logic                    is_read_q, is_read_d;
    logic                    abort_q, abort_d;
    logic [1:0]              dcnt_q, dcnt_d;
    logic [2:0]              wcnt_q, wcnt_d;
    logic                    ad_oe_q, ad_oe_d;
    logic                    par_oe_q, par_oe_d;
    logic                    par_q, par_d;
    logic [31:0]             mem [WORDS];

    logic        hit, cmd_ok, cmd_rd, last, xfer, assert_dev, devsel_oe;
    logic [31:0] rdata;

    assign rdata = mem[index_q];
    assign last  = &index_q;
    assign xfer  = (state_q == DATA) && !IRDY;
    assign hit   = ((AD & WIN_MASK) == (BASE_AD & WIN_MASK));

    always_comb begin
        cmd_ok = 1'b0;
        cmd_rd = 1'b0;
        case (CBE)
            4'b0110, 4'b1100, 4'b1110: begin cmd_ok = 1'b1; cmd_rd = 1'b1; end
            4'b0111, 4'b1111:          cmd_ok = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        is_read_d  = is_read_q;
        abort_d    = abort_q;
        dcnt_d     = dcnt_q;
        wcnt_d     = wcnt_q;
        ad_oe_d    = 1'b0;
        assert_dev = 1'b0;
        par_d      = ^{AD, CBE};
        par_oe_d   = ad_oe_q;
        case (state_q)
            IDLE: begin
                if (!FRAME) begin
                    if (hit && cmd_ok) begin
                        index_d   = AD[DEPTH_LOG2+1:2];
                        is_read_d = cmd_rd;
                        abort_d   = (AD[1:0] != 2'b00);
                        if (DD == 2'd0) begin
                            assert_dev = 1'b1;
                        end else begin
                            state_d = DECODE;
                            dcnt_d  = DD - 2'd1;
                        end
                    end else begin
                        state_d = BUS_BUSY;
                    end
                end
            end
            BUS_BUSY: if (FRAME && IRDY) state_d = IDLE;
            DECODE: begin
                if (FRAME && IRDY)        state_d = TURN_AR;
                else if (dcnt_q == 2'd0)  assert_dev = 1'b1;
                else                      dcnt_d = dcnt_q - 2'd1;
            end
            WAIT: begin
                ad_oe_d = is_read_q;
                if (FRAME && IRDY) begin
                    state_d = TURN_AR;
                    ad_oe_d = 1'b0;
                end else if (wcnt_q == 3'd0) begin
                    state_d = DATA;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            DATA: begin
                ad_oe_d = is_read_q;
                if (!IRDY) begin
                    index_d = index_q + DEPTH_LOG2'(1);
                    if (last || FRAME) begin
                        // Last word of the window was offered with STOP: disconnect unless the master already finished.
                        state_d = FRAME ? TURN_AR : STOPPING;
                        ad_oe_d = 1'b0;
                    end else if (WS != 3'd0) begin
                        state_d = WAIT;
                        wcnt_d  = WS - 3'd1;
                    end
                end
            end
            STOPPING: if (FRAME) state_d = TURN_AR;
            TURN_AR:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Reads spend one extra TRDY-high clock so the master can release AD.
        if (assert_dev) begin
            if (abort_d) begin
                state_d = STOPPING;
            end else if (is_read_d) begin
                state_d = WAIT;
                wcnt_d  = WS;
            end else if (WS != 3'd0) begin
                state_d = WAIT;
                wcnt_d  = WS - 3'd1;
            end else begin
                state_d = DATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (REST) begin
            state_q   <= IDLE;
            index_q   <= '0;
            is_read_q <= 1'b0;
            abort_q   <= 1'b0;
            dcnt_q    <= 2'd0;
            wcnt_q    <= 3'd0;
            ad_oe_q   <= 1'b0;
            par_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            is_read_q <= is_read_d;
            abort_q   <= abort_d;
            dcnt_q    <= dcnt_d;
            wcnt_q    <= wcnt_d;
            ad_oe_q   <= ad_oe_d;
            par_oe_q  <= par_oe_d;
        end
    end

    always_ff @(posedge CLK) begin
        par_q <= par_d;
        if (xfer && !is_read_q && !REST) begin
            for (int n = 0; n < 4; n++) begin
                if (!CBE[n]) mem[index_q][8*n +: 8] <= AD[8*n +: 8];
            end
        end
    end

    assign devsel_oe = (state_q == WAIT) || (state_q == DATA) ||
                       (state_q == STOPPING) || (state_q == TURN_AR);

    assign TRDY   = devsel_oe ? (state_q != DATA) : 1'bz;
    assign DEVSEL = devsel_oe ? ((state_q == TURN_AR) || ((state_q == STOPPING) && abort_q)) : 1'bz;
    assign STOP   = devsel_oe ? !(((state_q == DATA) && last) || (state_q == STOPPING)) : 1'bz;
    assign AD     = ad_oe_q  ? rdata : 32'bz;
    assign PAR    = par_oe_q ? par_q : 1'bz;

`ifdef PCI_TGT_PERR_EN
    logic chk_q, chk_d, perr_q, perr_d;

    // par_q still holds the parity of the previous write word when the master's PAR arrives.
    always_comb begin
        chk_d  = xfer && !is_read_q;
        perr_d = chk_q && (PAR != par_q);
    end

    always_ff @(posedge CLK) begin
        if (REST) begin
            chk_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            chk_q  <= chk_d;
            perr_q <= perr_d;
        end
    end

    assign PERR = perr_q ? 1'b0 : (devsel_oe ? 1'b1 : 1'bz);
`else
    assign PERR = 1'bz;
`endif

endmodule
